// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: checks sampled Hsync/Vsync against a fixed
// raster, locks after consecutive clean frames and recovers pixel position/colour.
module vga_rx_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_START     = 144,
    parameter int H_DISP      = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_START     = 35,
    parameter int V_DISP      = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_tick,
    input  logic       Hsync,
    input  logic       Vsync,
    input  logic [3:0] Red,
    input  logic [3:0] Green,
    input  logic [3:0] Blue,
    output logic       locked,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] rgb,
    output logic [9:0] line_len,
    output logic [7:0] frame_count,
    output logic [7:0] err_count
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] ALIGN  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [9:0]  H_TOTAL_W = 10'(H_TOTAL);
    localparam logic [6:0]  H_SYNC_W  = 7'(H_SYNC);
    localparam logic [9:0]  H_LO      = 10'(H_START);
    localparam logic [9:0]  H_HI      = 10'(H_START + H_DISP);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [9:0]  V_LO      = 10'(V_START);
    localparam logic [9:0]  V_HI      = 10'(V_START + V_DISP);
    localparam logic [7:0]  LOCK_W    = 8'(LOCK_FRAMES);
    localparam logic [9:0]  CNT_MAX   = '1;
    localparam logic [6:0]  LOW_MAX   = '1;

    // Registered history: previous Hsync sample and Vsync seen at the last line edge
    logic       hs_q;
    logic       vs_line_q;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [6:0] hs_low;
    logic [1:0] state;
    logic [7:0] good;
    logic       bad;

    logic       hs_fall;
    logic       hs_rise;
    logic       frame_start;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic [9:0] len_meas;
    logic [6:0] hs_low_next;
    logic       ovf_err;
    logic       len_err;
    logic       width_err;
    logic       line_fault;
    logic       lines_ok;
    logic [7:0] good_inc;
    logic [1:0] state_next;
    logic [7:0] good_next;
    logic       bad_next;
    logic [7:0] frame_next;
    logic [7:0] err_next;
    logic       in_window;
    logic [9:0] px_next;
    logic [9:0] py_next;
    logic [2:0] rgb_next;

    // Only the colour MSBs are recovered
    logic unused_low_bits;
    assign unused_low_bits = ^{Red[2:0], Green[2:0], Blue[2:0]};

    always_comb begin
        hs_fall     = hs_q & ~Hsync;
        hs_rise     = ~hs_q & Hsync;
        frame_start = hs_fall & ~Vsync & vs_line_q;

        len_meas = h_cnt + 10'd1;
        ovf_err  = 1'b0;
        if (hs_fall) begin
            h_next = '0;
        end else if (h_cnt == CNT_MAX) begin
            h_next = h_cnt;
        end else begin
            h_next  = h_cnt + 10'd1;
            ovf_err = (h_cnt == CNT_MAX - 10'd1);
        end

        if (!Hsync) begin
            if (hs_fall)
                hs_low_next = 7'd1;
            else if (hs_low == LOW_MAX)
                hs_low_next = hs_low;
            else
                hs_low_next = hs_low + 7'd1;
        end else begin
            hs_low_next = '0;
        end

        len_err    = hs_fall & (len_meas != H_TOTAL_W);
        width_err  = hs_rise & (hs_low != H_SYNC_W);
        line_fault = len_err | width_err | ovf_err;
        lines_ok   = ({1'b0, v_cnt} + 11'd1) == V_TOTAL_W;

        if (hs_fall) begin
            if (frame_start)
                v_next = '0;
            else if (v_cnt == CNT_MAX)
                v_next = v_cnt;
            else
                v_next = v_cnt + 10'd1;
        end else begin
            v_next = v_cnt;
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good;
        bad_next   = bad;
        frame_next = frame_count;
        err_next   = err_count;
        good_inc   = good + 8'd1;
        case (state)
            SEARCH: begin
                if (frame_start) begin
                    state_next = ALIGN;
                    good_next  = '0;
                    bad_next   = 1'b0;
                end
            end
            ALIGN: begin
                bad_next = bad | line_fault;
                // The line closed by this edge belongs to the frame being judged
                if (frame_start) begin
                    bad_next = 1'b0;
                    if (!(bad | line_fault) && lines_ok) begin
                        good_next = good_inc;
                        if (good_inc >= LOCK_W)
                            state_next = LOCKED;
                    end else begin
                        good_next = '0;
                    end
                end
            end
            LOCKED: begin
                if (line_fault | (frame_start & ~lines_ok)) begin
                    state_next = SEARCH;
                    if (err_count != 8'hFF)
                        err_next = err_count + 8'd1;
                end else if (frame_start) begin
                    frame_next = frame_count + 8'd1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_comb begin
        in_window = (state_next == LOCKED) &&
                    (h_next >= H_LO) && (h_next < H_HI) &&
                    (v_next >= V_LO) && (v_next < V_HI);
        px_next  = '0;
        py_next  = '0;
        rgb_next = '0;
        if (in_window) begin
            px_next  = h_next - H_LO;
            py_next  = v_next - V_LO;
            rgb_next = {Red[3], Green[3], Blue[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q        <= 1'b1;
            vs_line_q   <= 1'b1;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hs_low      <= '0;
            state       <= SEARCH;
            good        <= '0;
            bad         <= 1'b0;
            locked      <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            rgb         <= '0;
            line_len    <= '0;
            frame_count <= '0;
            err_count   <= '0;
        end else if (pix_tick) begin
            hs_q   <= Hsync;
            h_cnt  <= h_next;
            v_cnt  <= v_next;
            hs_low <= hs_low_next;
            if (hs_fall) begin
                vs_line_q <= Vsync;
                line_len  <= len_meas;
            end
            state       <= state_next;
            good        <= good_next;
            bad         <= bad_next;
            locked      <= (state_next == LOCKED);
            pix_valid   <= in_window;
            pix_x       <= px_next;
            pix_y       <= py_next;
            rgb         <= rgb_next;
            frame_count <= frame_next;
            err_count   <= err_next;
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a scaled-down raster with a tick-level behavioural model.
module tb_vga_rx_monitor;

    localparam int HT  = 12;
    localparam int HS  = 2;
    localparam int HST = 3;
    localparam int HD  = 6;
    localparam int VT  = 4;
    localparam int VST = 1;
    localparam int VD  = 2;
    localparam int LK  = 2;

    logic       clk;
    logic       reset;
    logic       pix_tick;
    logic       Hsync;
    logic       Vsync;
    logic [3:0] Red;
    logic [3:0] Green;
    logic [3:0] Blue;
    logic       locked;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [2:0] rgb;
    logic [9:0] line_len;
    logic [7:0] frame_count;
    logic [7:0] err_count;

    vga_rx_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_DISP(HD),
        .V_TOTAL(VT), .V_START(VST), .V_DISP(VD), .LOCK_FRAMES(LK)
    ) dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick),
        .Hsync(Hsync), .Vsync(Vsync), .Red(Red), .Green(Green), .Blue(Blue),
        .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .rgb(rgb), .line_len(line_len), .frame_count(frame_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [50:0] dut_vec;
    assign dut_vec = {locked, pix_valid, pix_x, pix_y, rgb, line_len, frame_count, err_count};

    int vectors = 0;
    int miscompares = 0;
    int gap = 1;
    bit rand_gap = 1'b0;

    // Reference model: raster position, run lengths and a lock level
    bit       m_prev_hs, m_vs_edge, m_bad, m_lk, m_valid;
    int       m_h, m_v, m_low, m_good, m_len, m_frames, m_err, m_px, m_py;
    bit [2:0] m_rgb;

    task automatic model_reset();
        m_prev_hs = 1; m_vs_edge = 1; m_bad = 0; m_lk = 0; m_valid = 0;
        m_h = 0; m_v = 0; m_low = 0; m_good = -1; m_len = 0;
        m_frames = 0; m_err = 0; m_px = 0; m_py = 0; m_rgb = '0;
    endtask

    task automatic model_step(input bit hs, input bit vs, input logic [3:0] r, g, b);
        bit fall, rise, fs, fault, frame_ok;
        fall  = m_prev_hs && !hs;
        rise  = !m_prev_hs && hs;
        fs    = fall && !vs && m_vs_edge;
        fault = 0;
        if (fall) begin
            m_len = (m_h + 1) % 1024;
            if (m_len != HT) fault = 1;
        end
        if (rise && m_low != HS) fault = 1;
        if (fall) m_h = 0;
        else if (m_h < 1023) begin
            m_h++;
            if (m_h == 1023) fault = 1;
        end
        if (!hs) m_low = fall ? 1 : (m_low < 127 ? m_low + 1 : 127);
        else     m_low = 0;
        frame_ok = (m_v + 1 == VT);
        if (fall) begin
            m_v = fs ? 0 : (m_v < 1023 ? m_v + 1 : 1023);
            m_vs_edge = vs;
        end
        m_prev_hs = hs;
        if (m_lk) begin
            if (fault || (fs && !frame_ok)) begin
                m_lk = 0; m_good = -1;
                if (m_err < 255) m_err++;
            end else if (fs) m_frames = (m_frames + 1) % 256;
        end else if (m_good < 0) begin
            if (fs) begin m_good = 0; m_bad = 0; end
        end else begin
            if (fault) m_bad = 1;
            if (fs) begin
                if (!m_bad && frame_ok) m_good++;
                else m_good = 0;
                m_bad = 0;
                if (m_good >= LK) m_lk = 1;
            end
        end
        m_valid = m_lk && m_h >= HST && m_h < HST + HD && m_v >= VST && m_v < VST + VD;
        m_px  = m_valid ? m_h - HST : 0;
        m_py  = m_valid ? m_v - VST : 0;
        m_rgb = m_valid ? {r[3], g[3], b[3]} : 3'b000;
    endtask

    function automatic logic [50:0] exp_vec();
        return {m_lk, m_valid, 10'(m_px), 10'(m_py), m_rgb, 10'(m_len), 8'(m_frames), 8'(m_err)};
    endfunction

    task automatic tick(input bit hs, input bit vs, input logic [3:0] r, g, b);
        int n;
        Hsync = hs; Vsync = vs; Red = r; Green = g; Blue = b;
        pix_tick = 1'b1;
        @(negedge clk);
        model_step(hs, vs, r, g, b);
        pix_tick = 1'b0;
        n = rand_gap ? int'($urandom_range(0, 3)) : gap;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_line(input int len, input int sw, input bit vs);
        for (int p = 0; p < len; p++)
            tick(p >= sw, vs, 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic send_frame(input int nl);
        for (int k = 0; k < nl; k++)
            send_line(HT, HS, k != 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (dut_vec !== '0) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=0", dut_vec);
        end
    endtask

    task automatic test_lock();
        gap = 1;
        send_frame(VT); send_frame(VT);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++; $display("FAIL lock_early got=%b exp=0", locked);
        end
        vectors++;
        if (line_len !== 10'(HT)) begin
            miscompares++; $display("FAIL lock_line_len got=%0d exp=%0d", line_len, HT);
        end
        send_frame(VT);
        vectors++;
        if ({locked, frame_count} !== {1'b1, 8'd0}) begin
            miscompares++; $display("FAIL lock_third got=%b/%0d exp=1/0", locked, frame_count);
        end
        for (int f = 0; f < 4; f++) begin
            send_frame(VT);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++; $display("FAIL lock_frame got=%h exp=%h", dut_vec, exp_vec());
            end
        end
        vectors++;
        if ({frame_count, err_count} !== {8'd4, 8'd0}) begin
            miscompares++; $display("FAIL lock_counts got=%0d/%0d exp=4/0", frame_count, err_count);
        end
    endtask

    task automatic test_pixel();
        for (int k = 0; k < VT; k++)
            for (int p = 0; p < HT; p++) begin
                logic [3:0] r;
                r = (k == VST && p == HST) ? 4'hF : 4'h0;
                tick(p >= HS, k != 0, r, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
                vectors++;
                if (dut_vec !== exp_vec()) begin
                    miscompares++; $display("FAIL pixel_stream k=%0d p=%0d got=%h exp=%h", k, p, dut_vec, exp_vec());
                end
                if (k == VST && p == HST) begin
                    vectors++;
                    if ({pix_valid, pix_x, pix_y, rgb} !== {1'b1, 10'd0, 10'd0, 3'b100}) begin
                        miscompares++; $display("FAIL pixel_first got=%b/%0d/%0d/%b exp=1/0/0/100", pix_valid, pix_x, pix_y, rgb);
                    end
                end
                if (k == VST && p == HST - 1) begin
                    vectors++;
                    if (pix_valid !== 1'b0) begin
                        miscompares++; $display("FAIL pixel_before got=%b exp=0", pix_valid);
                    end
                end
                if (k == VST + VD - 1 && p == HST + HD - 1) begin
                    vectors++;
                    if ({pix_valid, pix_x, pix_y} !== {1'b1, 10'(HD - 1), 10'(VD - 1)}) begin
                        miscompares++; $display("FAIL pixel_last got=%b/%0d/%0d exp=1/%0d/%0d", pix_valid, pix_x, pix_y, HD - 1, VD - 1);
                    end
                end
            end
        send_frame(VT);
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++; $display("FAIL pixel_after got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_short_line();
        logic [7:0] e0;
        e0 = err_count;
        send_line(HT, HS, 1'b0);
        send_line(HT - 1, HS, 1'b1);
        send_line(HT, HS, 1'b1);
        vectors++;
        if ({line_len, err_count, locked} !== {10'(HT - 1), e0 + 8'd1, 1'b0}) begin
            miscompares++; $display("FAIL short_line got=%0d/%0d/%b exp=%0d/%0d/0", line_len, err_count, locked, HT - 1, e0 + 8'd1);
        end
        send_line(HT, HS, 1'b1);
        send_frame(VT); send_frame(VT);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++; $display("FAIL short_relock_early got=%b exp=0", locked);
        end
        send_frame(VT);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++; $display("FAIL short_relock got=%b exp=1", locked);
        end
    endtask

    task automatic test_hsync_width();
        logic [7:0] e0;
        e0 = err_count;
        send_line(HT, HS, 1'b0);
        send_line(HT, HS - 1, 1'b1);
        vectors++;
        if ({err_count, locked} !== {e0 + 8'd1, 1'b0}) begin
            miscompares++; $display("FAIL hsync_width got=%0d/%b exp=%0d/0", err_count, locked, e0 + 8'd1);
        end
        send_line(HT, HS, 1'b1); send_line(HT, HS, 1'b1);
        send_frame(VT); send_frame(VT); send_frame(VT);
        send_frame(VT + 2);
        vectors++;
        if ({err_count, locked} !== {e0 + 8'd1, 1'b1}) begin
            miscompares++; $display("FAIL long_frame_pre got=%0d/%b exp=%0d/1", err_count, locked, e0 + 8'd1);
        end
        send_line(HT, HS, 1'b0);
        vectors++;
        if ({err_count, locked} !== {e0 + 8'd2, 1'b0}) begin
            miscompares++; $display("FAIL long_frame got=%0d/%b exp=%0d/0", err_count, locked, e0 + 8'd2);
        end
    endtask

    task automatic test_stuck();
        logic [7:0] e0;
        send_line(HT, HS, 1'b1);
        send_frame(VT); send_frame(VT); send_frame(VT);
        e0 = err_count;
        gap = 0;
        send_line(1100 + HS, HS, 1'b0);
        vectors++;
        if ({err_count, locked, pix_valid} !== {e0 + 8'd1, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL stuck_err got=%0d/%b/%b exp=%0d/0/0", err_count, locked, pix_valid, e0 + 8'd1);
        end
        send_line(HT, HS, 1'b1);
        vectors++;
        if ({line_len, err_count} !== {10'd0, e0 + 8'd1}) begin
            miscompares++; $display("FAIL stuck_hold got=%0d/%0d exp=0/%0d", line_len, err_count, e0 + 8'd1);
        end
    endtask

    task automatic test_saturate();
        gap = 0;
        for (int c = 0; c < 300 && m_err < 255; c++) begin
            send_frame(VT); send_frame(VT);
            send_line(HT - 1, HS, 1'b0);
            send_line(HT, HS, 1'b1);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++; $display("FAIL saturate_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++; $display("FAIL saturate_top got=%0d exp=255", err_count);
        end
        send_frame(VT); send_frame(VT);
        send_line(HT - 1, HS, 1'b0);
        send_line(HT, HS, 1'b1);
        vectors++;
        if ({err_count, locked} !== {8'd255, 1'b0}) begin
            miscompares++; $display("FAIL saturate_hold got=%0d/%b exp=255/0", err_count, locked);
        end
        gap = 1;
    endtask

    task automatic test_reset_mid();
        send_frame(VT); send_frame(VT); send_frame(VT);
        send_line(HT, HS, 1'b0); send_line(HT, HS, 1'b1);
        reset = 1'b1; pix_tick = 1'b1; Hsync = 1'b0; Vsync = 1'b0;
        @(negedge clk);
        reset = 1'b0; pix_tick = 1'b0;
        model_reset();
        vectors++;
        if (dut_vec !== '0) begin
            miscompares++; $display("FAIL reset_mid got=%h exp=0", dut_vec);
        end
        send_line(HT, HS, 1'b1); send_line(HT, HS, 1'b1);
        send_frame(VT); send_frame(VT);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++; $display("FAIL reset_relock_early got=%b exp=0", locked);
        end
        send_frame(VT);
        vectors++;
        if ({locked, frame_count, err_count} !== {1'b1, 8'd0, 8'd0}) begin
            miscompares++; $display("FAIL reset_relock got=%b/%0d/%0d exp=1/0/0", locked, frame_count, err_count);
        end
    endtask

    task automatic test_random();
        rand_gap = 1'b1;
        for (int f = 0; f < 16; f++)
            for (int k = 0; k < VT; k++) begin
                int len;
                int sw;
                len = HT; sw = HS;
                case ($urandom_range(0, 23))
                    0: len = HT - 1;
                    1: len = HT + 1;
                    2: sw = HS + 1;
                    3: sw = HS - 1;
                    default: ;
                endcase
                send_line(len, sw, k != 0);
                vectors++;
                if (dut_vec !== exp_vec()) begin
                    miscompares++; $display("FAIL random f=%0d k=%0d got=%h exp=%h", f, k, dut_vec, exp_vec());
                end
            end
        rand_gap = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pix_tick = 1'b0; Hsync = 1'b1; Vsync = 1'b1;
        Red = '0; Green = '0; Blue = '0;
        model_reset();
        test_reset();
        test_lock();
        test_pixel();
        test_short_line();
        test_hsync_width();
        test_stuck();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
